bcd_xs3_codec: RTL and testbench

BCD_XS3_CODEC -- requirements
Module: bcd_xs3_codec

---
 rtl/bcd_xs3_codec.sv | 163 ++++++++++++++++
 tb/tb_bcd_xs3_codec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_codec.sv
// ---------------------------------------------------------------------------
// bcd_xs3_codec
//   Converts a packed word of DIGITS 4-bit digits between BCD and Excess-3.
//   The conversion is serial: one digit per clock, digit 0 first.
//   It is controlled by a three-state FSM (IDLE -> CONV -> DONE).
//
//   MODE = 0 : BCD -> Excess-3.
//              Valid digits are 0..9 and the result is digit + 3.
//   MODE = 1 : Excess-3 -> BCD.
//              Valid digits are 3..12 and the result is digit - 3.
//   An invalid digit produces nibble 4'hF and sets its err_mask bit.
//
// Ports
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data holds a word to convert
//   in_ready  : block can accept a word (high only in IDLE)
//   in_data   : packed input digits, digit 0 in bits [3:0]
//   out_valid : out_data / err_mask hold a finished result
//   out_ready : consumer takes the result
//   out_data  : converted word, same packing as in_data
//   err_mask  : bit i set = input digit i was invalid
//   busy      : high while converting (CONV state)
//
// Handshake
//   Both ports use valid/ready. A word is accepted on a rising edge where
//   in_valid & in_ready. A result is transferred on a rising edge where
//   out_valid & out_ready. While out_valid is high, out_data and err_mask
//   hold stable until the transfer edge. There is no bypass: a new word is
//   accepted no earlier than the edge after a transfer.
// ---------------------------------------------------------------------------
module bcd_xs3_codec #(
  parameter int DIGITS = 4,
  parameter int MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  busy
);

  localparam int CW = $clog2(DIGITS) + 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      word_q;   // input word latched on accept
  logic [W-1:0]      res_q;    // partial result built during CONV
  logic [DIGITS-1:0] err_q;    // partial error mask built during CONV

  logic [3:0]        cur_digit;
  logic [3:0]        cur_res;
  logic              cur_err;
  logic [W-1:0]      res_next;
  logic [DIGITS-1:0] err_next;
  logic              last_digit;

  // Select the digit addressed by the counter.
  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) cur_digit = word_q[4*i +: 4];
    end
  end

  // Per-digit conversion. Each nibble is independent: no carry or borrow
  // passes between digits.
  always_comb begin
    cur_res = 4'hF;
    cur_err = 1'b1;
    if (MODE == 0) begin
      if (cur_digit <= 4'd9) begin
        cur_res = cur_digit + 4'd3;
        cur_err = 1'b0;
      end
    end else begin
      if ((cur_digit >= 4'd3) && (cur_digit <= 4'd12)) begin
        cur_res = cur_digit - 4'd3;
        cur_err = 1'b0;
      end
    end
  end

  // Merge the current nibble into the partial result. The merged value is
  // what gets published on the last digit, so out_data is updated exactly
  // once per word. No partial result ever reaches the outputs.
  always_comb begin
    res_next = res_q;
    err_next = err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        res_next[4*i +: 4] = cur_res;
        err_next[i]        = cur_err;
      end
    end
  end

  assign last_digit = (cnt == CW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      word_q    <= '0;
      res_q     <= '0;
      err_q     <= '0;
      out_data  <= '0;
      err_mask  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            word_q   <= in_data;
            cnt      <= '0;
            res_q    <= '0;
            err_q    <= '0;
            err_mask <= '0;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          res_q <= res_next;
          err_q <= err_next;
          if (last_digit) begin
            out_data  <= res_next;
            err_mask  <= err_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_CONV);

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_codec
//   Directed bench for bcd_xs3_codec. It drives four instances in lockstep:
//     u0 : MODE 0, DIGITS 4
//     u1 : MODE 1, DIGITS 4
//     u2 : MODE 0, DIGITS 1
//     u3 : MODE 1, DIGITS 1
//   in_valid and out_ready are shared by all instances. Each instance has
//   its own in_data.
//   Inputs are driven on the falling edge. Outputs are sampled on the
//   falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_codec;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        in_valid;
  logic        out_ready;

  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  c_in;
  logic [3:0]  d_in;

  logic        ir0, ov0, bz0;
  logic [15:0] od0;
  logic [3:0]  em0;

  logic        ir1, ov1, bz1;
  logic [15:0] od1;
  logic [3:0]  em1;

  logic        ir2, ov2, bz2;
  logic [3:0]  od2;
  logic [0:0]  em2;

  logic        ir3, ov3, bz3;
  logic [3:0]  od3;
  logic [0:0]  em3;

  bcd_xs3_codec #(.DIGITS(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .in_data(a_in), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .err_mask(em0), .busy(bz0));

  bcd_xs3_codec #(.DIGITS(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(b_in), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .err_mask(em1), .busy(bz1));

  bcd_xs3_codec #(.DIGITS(1), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .in_data(c_in), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .err_mask(em2), .busy(bz2));

  bcd_xs3_codec #(.DIGITS(1), .MODE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .in_data(d_in), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .err_mask(em3), .busy(bz3));

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Reference digit conversions for the DIGITS=1 sweep.
  function automatic logic [3:0] ref_x3(input logic [3:0] v);
    return (v <= 4'd9) ? v + 4'd3 : 4'hF;
  endfunction
  function automatic logic [3:0] ref_bcd(input logic [3:0] v);
    return (v >= 4'd3 && v <= 4'd12) ? v - 4'd3 : 4'hF;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one word to every instance and checks the latency and results.
  // It must be called just after a falling edge with all instances in IDLE.
  // It returns just after edge 4, with every instance in DONE.
  task automatic run_word(
    input logic [15:0] a, input logic [15:0] b,
    input logic [3:0]  c, input logic [3:0]  d,
    input logic [15:0] ea, input logic [3:0] ma,
    input logic [15:0] eb, input logic [3:0] mb,
    input logic [3:0]  ec, input logic       mc,
    input logic [3:0]  ed, input logic       md);
    a_in = a; b_in = b; c_in = c; d_in = d;
    in_valid = 1'b1;
    @(negedge clk);                       // after edge 0 (accept)
    in_valid = 1'b0;
    // Scramble the inputs: they must have no effect after the accept.
    a_in = 16'($urandom_range(0, 65535));
    b_in = 16'($urandom_range(0, 65535));
    c_in = 4'($urandom_range(0, 15));
    d_in = 4'($urandom_range(0, 15));
    check("busy_after_accept", bz0, 1);
    check("in_ready_after_accept", ir0, 0);
    check("ov_after_accept", ov0, 0);
    @(negedge clk);                       // after edge 1
    check("d1m0_ov", ov2, 1);
    check("d1m0_data", od2, ec);
    check("d1m0_err", em2, mc);
    check("d1m1_ov", ov3, 1);
    check("d1m1_data", od3, ed);
    check("d1m1_err", em3, md);
    check("d4_ov_edge1", ov0, 0);
    repeat (2) @(negedge clk);            // after edge 3
    check("d4_ov_edge3", ov0, 0);
    check("d4_busy_edge3", bz0, 1);
    @(negedge clk);                       // after edge 4
    check("d4m0_ov", ov0, 1);
    check("d4m0_busy", bz0, 0);
    check("d4m0_data", od0, ea);
    check("d4m0_err", em0, ma);
    check("d4m1_ov", ov1, 1);
    check("d4m1_data", od1, eb);
    check("d4m1_err", em1, mb);
  endtask

  // Performs the transfer and checks the return to IDLE with data retained.
  task automatic transfer(input logic [15:0] ea);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("xfer_ov0", ov0, 0);
    check("xfer_ir0", ir0, 1);
    check("xfer_ov2", ov2, 0);
    check("xfer_ir2", ir2, 1);
    check("xfer_retain", od0, ea);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;

    // Assert reset mid-cycle and check the outputs before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_ov", ov0, 0);
    check("rst_data", od0, 16'h0000);
    check("rst_err", em0, 0);
    check("rst_busy", bz0, 0);
    check("rst_ir", ir0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;   // the first rising edge with rst_n high accepts the word

    // MODE 0 and MODE 1 inputs with all digits valid.
    run_word(16'h1239, 16'h456C, 4'h5, 4'h8,
             16'h456C, 4'b0000, 16'h1239, 4'b0000,
             4'h8, 1'b0, 4'h5, 1'b0);
    transfer(16'h456C);

    // Inputs containing invalid digits.
    run_word(16'h0A95, 16'h2D33, 4'hA, 4'h2,
             16'h3FC8, 4'b0100, 16'hFF00, 4'b1100,
             4'hF, 1'b1, 4'hF, 1'b1);
    transfer(16'h3FC8);

    // Backpressure: hold DONE for 5 cycles and pulse in_valid once.
    // The pulse must be ignored.
    run_word(16'h1239, 16'h456C, 4'h0, 4'hC,
             16'h456C, 4'b0000, 16'h1239, 4'b0000,
             4'h3, 1'b0, 4'h9, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        a_in = 16'h9999;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_data", od0, 16'h456C);
      check("bp_ov", ov0, 1);
      check("bp_ir", ir0, 0);
    end
    in_valid = 1'b0;
    transfer(16'h456C);
    @(negedge clk);
    check("bp_pulse_ignored", bz0, 0);

    // Reset after two CONV cycles aborts the word.
    a_in = 16'h1239; b_in = 16'h456C; c_in = 4'h1; d_in = 4'h4;
    in_valid = 1'b1;
    @(negedge clk);          // after the accept edge
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bz0, 0);
    check("abort_ov0", ov0, 0);
    check("abort_data", od0, 16'h0000);
    check("abort_ov2", ov2, 0);
    check("abort_ir", ir0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(16'h0000, 16'h0000, 4'h0, 4'h0,
             16'h3333, 4'b0000, 16'hFFFF, 4'b1111,
             4'h3, 1'b0, 4'hF, 1'b1);
    transfer(16'h3333);

    // Exhaustive sweep of every digit value 0..F.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] n;
      n = 4'(v);
      run_word({4{n}}, {4{n}}, n, n,
               {4{ref_x3(n)}}, {4{ref_x3(n) == 4'hF}},
               {4{ref_bcd(n)}}, {4{ref_bcd(n) == 4'hF}},
               ref_x3(n), ref_x3(n) == 4'hF,
               ref_bcd(n), ref_bcd(n) == 4'hF);
      transfer({4{ref_x3(n)}});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
